uart_tx: RTL and testbench

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_tx.sv | 138 +++++++++++++
 tb/tb_uart_tx.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: start bit, LSB-first payload, optional parity, stop bit.
// Bit period is set per frame from the prescale value captured at accept.
module uart_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      i_uart_clk,
    input  logic                      i_arst_n,
    input  logic [DATA_WIDTH-1:0]     i_data,
    input  logic                      i_data_valid,
    input  logic                      i_par_en,
    input  logic                      i_par_typ,
    input  logic [PRESCALE_WIDTH-1:0] i_prescale,
    output logic                      o_tx_out,
    output logic                      o_busy,
    output logic                      o_data_ack
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                    state_q, state_d;
    logic [PRESCALE_WIDTH-1:0] cnt_q, cnt_d;
    logic [PRESCALE_WIDTH-1:0] p_q, p_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [DATA_WIDTH-1:0]     data_q, data_d;
    logic                      par_en_q, par_en_d;
    logic                      par_typ_q, par_typ_d;
    logic                      tx_d, busy_d, ack_d;
    logic                      bit_done;
    logic                      load;

    // Next state, counters, frame capture and next registered outputs.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        idx_d     = idx_q;
        data_d    = data_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        load      = 1'b0;
        ack_d     = 1'b0;
        tx_d      = 1'b1;
        busy_d    = 1'b0;
        bit_done  = (cnt_q == p_q - PRESCALE_WIDTH'(1));

        unique case (state_q)
            IDLE: begin
                if (i_data_valid) load = 1'b1;
            end
            START: begin
                if (bit_done) state_d = DATA;
            end
            DATA: begin
                if (bit_done) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = par_en_q ? PARITY : STOP;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            PARITY: begin
                if (bit_done) state_d = STOP;
            end
            STOP: begin
                if (bit_done) begin
                    if (i_data_valid) load = 1'b1;
                    else state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE) begin
            cnt_d = bit_done ? '0 : cnt_q + PRESCALE_WIDTH'(1);
        end

        if (load) begin
            state_d   = START;
            data_d    = i_data;
            par_en_d  = i_par_en;
            par_typ_d = i_par_typ;
            p_d       = (i_prescale == '0) ? PRESCALE_WIDTH'(1) : i_prescale;
            cnt_d     = '0;
            idx_d     = '0;
            ack_d     = 1'b1;
        end

        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = data_d[idx_d];
            PARITY:  tx_d = (^data_d) ^ par_typ_d;
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, frame context and output registers with synchronous reset.
    always_ff @(posedge i_uart_clk) begin
        if (!i_arst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            p_q        <= '0;
            idx_q      <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_typ_q  <= 1'b0;
            o_tx_out   <= 1'b1;
            o_busy     <= 1'b0;
            o_data_ack <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            p_q        <= p_d;
            idx_q      <= idx_d;
            data_q     <= data_d;
            par_en_q   <= par_en_d;
            par_typ_q  <= par_typ_d;
            o_tx_out   <= tx_d;
            o_busy     <= busy_d;
            o_data_ack <= ack_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Randomized scoreboard bench for uart_tx: stimulus pushes expected line
// waveforms, a monitor pops and compares them cycle by cycle.
module tb_uart_tx;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] data;
    logic          valid;
    logic          pe;
    logic          pt;
    logic [PW-1:0] ps;
    logic          tx;
    logic          busy;
    logic          ack;

    int checks;
    int errors;

    bit exp_bits[$];
    int exp_len[$];
    bit exp_b2b[$];

    uart_tx #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
        .i_uart_clk   (clk),
        .i_arst_n     (rst_n),
        .i_data       (data),
        .i_data_valid (valid),
        .i_par_en     (pe),
        .i_par_typ    (pt),
        .i_prescale   (ps),
        .o_tx_out     (tx),
        .o_busy       (busy),
        .o_data_ack   (ack)
    );

    initial clk = 1'b0;
    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
                     $time);
        end
    endtask

    function automatic int frame_len(input bit pe_, input logic [PW-1:0] ps_);
        int p;
        p = (ps_ == 0) ? 1 : int'(ps_);
        return (DW + 2 + (pe_ ? 1 : 0)) * p;
    endfunction

    // Reference: bit list of the frame, each bit stretched to P cycles.
    function automatic void push_frame(input logic [DW-1:0] d, input bit pe_,
                                       input bit pt_, input logic [PW-1:0] ps_,
                                       input bit b2b);
        bit seq[$];
        int p;
        p = (ps_ == 0) ? 1 : int'(ps_);
        seq.push_back(1'b0);
        for (int i = 0; i < DW; i++) seq.push_back(d[i]);
        if (pe_) seq.push_back((($countones(d) % 2) == 1) ^ pt_);
        seq.push_back(1'b1);
        foreach (seq[k]) begin
            for (int r = 0; r < p; r++) exp_bits.push_back(seq[k]);
        end
        exp_len.push_back(seq.size() * p);
        exp_b2b.push_back(b2b);
    endfunction

    task automatic issue(input logic [DW-1:0] d, input bit pe_, input bit pt_,
                         input logic [PW-1:0] ps_, input bit b2b);
        data  = d;
        pe    = pe_;
        pt    = pt_;
        ps    = ps_;
        valid = 1'b1;
        push_frame(d, pe_, pt_, ps_, b2b);
    endtask

    task automatic wait_ack(output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        for (int n = 1; n <= 2000; n++) begin
            @(negedge clk);
            if (ack) begin
                lat = n;
                got = 1'b1;
                break;
            end
        end
        if (!got) check("ack_timeout", 0, 1);
    endtask

    task automatic release_and_idle(input int gap);
        bit idle;
        valid = 1'b0;
        data  = DW'($urandom);
        pe    = 1'($urandom);
        pt    = 1'($urandom);
        ps    = PW'($urandom);
        idle  = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (!busy) begin
                idle = 1'b1;
                break;
            end
        end
        if (!idle) check("busy_timeout", 0, 1);
        repeat (gap) @(negedge clk);
    endtask

    // Monitor: compares line, busy and ack against the expected queues.
    initial begin
        int pos;
        int len;
        bit was_rst;
        bit b;
        pos = 0;
        len = 0;
        forever begin
            @(posedge clk);
            was_rst = !rst_n;
            @(negedge clk);
            if (was_rst) begin
                while (pos < len && exp_bits.size() > 0) begin
                    b = exp_bits.pop_front();
                    pos++;
                end
                pos = 0;
                len = 0;
                check("rst_tx", tx, 1);
                check("rst_busy", busy, 0);
                check("rst_ack", ack, 0);
                continue;
            end
            if (ack) begin
                check("ack_early", pos, len);
                while (pos < len && exp_bits.size() > 0) begin
                    b = exp_bits.pop_front();
                    pos++;
                end
                if (exp_len.size() == 0) begin
                    check("ack_spurious", ack, 0);
                    pos = 0;
                    len = 0;
                end else begin
                    len = exp_len.pop_front();
                    b   = exp_b2b.pop_front();
                    pos = 0;
                end
            end else if (pos == len && len != 0 && exp_b2b.size() > 0
                         && exp_b2b[0]) begin
                check("b2b_gap", ack, 1);
                exp_b2b[0] = 1'b0;
            end
            if (pos < len && exp_bits.size() > 0) begin
                b = exp_bits.pop_front();
                check("tx_bit", tx, b);
                check("busy_frame", busy, 1);
                pos++;
            end else begin
                check("idle_tx", tx, 1);
                check("idle_busy", busy, 0);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Stimulus: directed cases, then randomized frames.
    initial begin
        int lat;
        int prev_len;
        logic [DW-1:0] d;
        bit pe_, pt_;
        logic [PW-1:0] ps_;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        valid  = 1'b0;
        data   = '0;
        pe     = 1'b0;
        pt     = 1'b0;
        ps     = PW'(1);
        repeat (3) @(negedge clk);

        rst_n = 1'b1;
        issue(8'hA5, 0, 0, 1, 0);
        wait_ack(lat);
        check("first_accept_lat", lat, 1);
        release_and_idle(2);

        issue(8'hA5, 1, 0, 1, 0);
        wait_ack(lat);
        release_and_idle(1);
        issue(8'hA5, 1, 1, 1, 0);
        wait_ack(lat);
        release_and_idle(0);

        issue(8'h01, 0, 0, 4, 0);
        wait_ack(lat);
        release_and_idle(2);

        issue(8'h55, 0, 0, 1, 0);
        wait_ack(lat);
        issue(8'hAA, 0, 0, 1, 1);
        wait_ack(lat);
        check("b2b_ack_spacing", lat, 10);
        release_and_idle(2);

        issue(8'hC3, 0, 0, 2, 0);
        wait_ack(lat);
        valid = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        issue(8'h3C, 0, 0, 2, 0);
        wait_ack(lat);
        check("post_rst_accept_lat", lat, 1);
        release_and_idle(1);

        issue(8'h5A, 1, 0, 0, 0);
        wait_ack(lat);
        release_and_idle(1);

        d   = DW'($urandom);
        pe_ = 1'($urandom);
        pt_ = 1'($urandom);
        ps_ = PW'($urandom_range(0, 5));
        issue(d, pe_, pt_, ps_, 0);
        prev_len = frame_len(pe_, ps_);
        wait_ack(lat);
        for (int i = 0; i < 40; i++) begin
            d   = DW'($urandom);
            pe_ = 1'($urandom);
            pt_ = 1'($urandom);
            ps_ = PW'($urandom_range(0, 5));
            if ($urandom_range(0, 1) == 1) begin
                issue(d, pe_, pt_, ps_, 1);
                wait_ack(lat);
                check("rand_b2b_spacing", lat, prev_len);
            end else begin
                release_and_idle($urandom_range(0, 3));
                issue(d, pe_, pt_, ps_, 0);
                wait_ack(lat);
                check("rand_accept_lat", lat, 1);
            end
            prev_len = frame_len(pe_, ps_);
        end
        release_and_idle(3);

        check("frames_left", exp_len.size(), 0);
        check("bits_left", exp_bits.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
